// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths and capture state encoding for adc_result_capture
package adc_pkg;

    localparam int ADC_COUNT_W = 24;
    localparam int SEQ_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        READ = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cs_sync_edge.sv
// rtl/cs_sync_edge.sv - two-flop synchronizer with single-cycle fall/rise pulses
module cs_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_in,
    output logic cs_sync,
    output logic cs_fall,
    output logic cs_rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= cs_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign cs_sync = sync_q;
    assign cs_fall = prev_q & ~sync_q;
    assign cs_rise = ~prev_q & sync_q;

endmodule

// File: rtl/adc_result_capture.sv
// rtl/adc_result_capture.sv - ADC count snapshot with SPI read freeze, shadow slot and host interrupt
// Optional self-clearing interrupt timeout: ADC_INT_TIMEOUT_EN
module adc_result_capture
    import adc_pkg::*;
#(
    parameter int WIDTH        = ADC_COUNT_W,
    parameter int INT_MIN_HOLD = 16,
    parameter int INT_TIMEOUT  = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_strobe,
    input  logic [WIDTH-1:0] count_up_in,
    input  logic [WIDTH-1:0] count_down_in,
    input  logic [WIDTH-1:0] count_rundown_in,
    input  logic             spi_cs,
    output logic [WIDTH-1:0] count_up,
    output logic [WIDTH-1:0] count_down,
    output logic [WIDTH-1:0] count_rundown,
    output logic [SEQ_W-1:0] seq,
    output logic             overrun,
    output logic             int_n
);

    localparam int                HOLD_W   = $clog2(INT_MIN_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(INT_MIN_HOLD - 1);

    logic cs_fall, cs_rise, unused_cs_sync;

    cs_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs_in   (spi_cs),
        .cs_sync (unused_cs_sync),
        .cs_fall (cs_fall),
        .cs_rise (cs_rise)
    );

    cap_state_e         state_q, state_d;
    logic [3*WIDTH-1:0] snap_q, snap_d, shadow_q, shadow_d;
    logic               sh_full_q, sh_full_d;
    logic               rd_ovr_q, rd_ovr_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               ovr_q, ovr_d;
    logic               int_n_q, int_n_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               capture;
    logic               tmo_hit;
    logic [3*WIDTH-1:0] in_cnt;

    assign in_cnt = {count_up_in, count_down_in, count_rundown_in};

`ifdef ADC_INT_TIMEOUT_EN
    logic [21:0] tmo_q;

    assign tmo_hit = (state_q == PEND) && (tmo_q == 22'(INT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_q <= '0;
        else if (capture)
            tmo_q <= '0;
        else if (state_q == PEND)
            tmo_q <= tmo_q + 22'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = |INT_TIMEOUT;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        sh_full_d = sh_full_q;
        rd_ovr_d  = rd_ovr_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q;
        int_n_d   = int_n_q;
        hold_d    = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        capture   = 1'b0;

        case (state_q)
            IDLE, PEND: begin
                if (done_strobe) begin
                    capture = 1'b1;
                    snap_d  = in_cnt;
                    state_d = PEND;
                    if (state_q == PEND)
                        ovr_d = 1'b1;
                end else if (tmo_hit && !cs_fall) begin
                    int_n_d = 1'b1;
                    ovr_d   = 1'b1;
                    state_d = IDLE;
                end
                // Capture and CS fall in one cycle: capture lands, then the read freezes it.
                if (cs_fall) begin
                    state_d  = READ;
                    rd_ovr_d = 1'b0;
                end
            end
            READ: begin
                if (hold_q == HOLD_MAX)
                    int_n_d = 1'b1;
                if (cs_rise) begin
                    sh_full_d = 1'b0;
                    rd_ovr_d  = 1'b0;
                    ovr_d     = rd_ovr_q;
                    if (done_strobe) begin
                        capture = 1'b1;
                        snap_d  = in_cnt;
                        state_d = PEND;
                        if (sh_full_q)
                            ovr_d = 1'b1;
                    end else if (sh_full_q) begin
                        capture = 1'b1;
                        snap_d  = shadow_q;
                        state_d = PEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (done_strobe) begin
                    shadow_d  = in_cnt;
                    sh_full_d = 1'b1;
                    if (sh_full_q) begin
                        ovr_d    = 1'b1;
                        rd_ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            seq_d   = seq_q + 1'b1;
            int_n_d = 1'b0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            shadow_q  <= '0;
            sh_full_q <= 1'b0;
            rd_ovr_q  <= 1'b0;
            seq_q     <= '0;
            ovr_q     <= 1'b0;
            int_n_q   <= 1'b1;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
            sh_full_q <= sh_full_d;
            rd_ovr_q  <= rd_ovr_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            int_n_q   <= int_n_d;
            hold_q    <= hold_d;
        end
    end

    assign {count_up, count_down, count_rundown} = snap_q;
    assign seq     = seq_q;
    assign overrun = ovr_q;
    assign int_n   = int_n_q;

endmodule

// File: tb/tb_adc_result_capture.sv
// tb/tb_adc_result_capture.sv - scoreboard bench for adc_result_capture (define ADC_INT_TIMEOUT_EN for timeout test)
module tb_adc_result_capture;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         done_strobe;
    logic [W-1:0] up_in, dn_in, rd_in;
    logic         spi_cs;
    logic [W-1:0] count_up, count_down, count_rundown;
    logic [7:0]   seq;
    logic         overrun;
    logic         int_n;

    typedef struct packed {
        logic [W-1:0] up;
        logic [W-1:0] down;
        logic [W-1:0] rd;
        logic [7:0]   seq;
    } snap_t;

    snap_t      exp_q[$];
    logic [7:0] exp_seq;
    int         n_tests = 0;
    int         n_fail  = 0;

    adc_result_capture #(
        .WIDTH        (W),
        .INT_MIN_HOLD (16),
        .INT_TIMEOUT  (100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .done_strobe      (done_strobe),
        .count_up_in      (up_in),
        .count_down_in    (dn_in),
        .count_rundown_in (rd_in),
        .spi_cs           (spi_cs),
        .count_up         (count_up),
        .count_down       (count_down),
        .count_rundown    (count_rundown),
        .seq              (seq),
        .overrun          (overrun),
        .int_n            (int_n)
    );

    always #5 clk = ~clk;

    // Any visible change of the snapshot must match the next queued expectation.
    snap_t last_obs = '0;
    always @(negedge clk) begin
        snap_t cur;
        snap_t e;
        cur = {count_up, count_down, count_rundown, seq};
        if (!rst_n) begin
            last_obs = '0;
        end else if (cur !== last_obs) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got up=%h down=%h rd=%h seq=%0d, required no change",
                         count_up, count_down, count_rundown, seq);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL sb_snapshot: got up=%h down=%h rd=%h seq=%0d, required up=%h down=%h rd=%h seq=%0d",
                             count_up, count_down, count_rundown, seq, e.up, e.down, e.rd, e.seq);
                end
            end
            last_obs = cur;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        done_strobe = 1'b0;
        spi_cs      = 1'b1;
        up_in       = '0;
        dn_in       = '0;
        rd_in       = '0;
        exp_q.delete();
        exp_seq     = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic strobe(input logic [W-1:0] u, input logic [W-1:0] d, input logic [W-1:0] r,
                          input bit visible);
        done_strobe = 1'b1;
        up_in = u;
        dn_in = d;
        rd_in = r;
        if (visible) begin
            exp_seq = exp_seq + 8'd1;
            exp_q.push_back({u, d, r, exp_seq});
        end
        tick();
        done_strobe = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({count_up, count_down, count_rundown} !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h/%h/%h, required 0", count_up, count_down, count_rundown);
        end
        n_tests++;
        if (seq !== 8'd0) begin n_fail++; $display("FAIL reset_seq: got %0d, required 0", seq); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        n_tests++;
        if (int_n !== 1'b1) begin n_fail++; $display("FAIL reset_int_n: got %b, required 1", int_n); end
    endtask

    task automatic test_capture_read();
        do_reset();
        strobe(24'h000123, 24'h000456, 24'h0007A9, 1'b1);
        n_tests++;
        if (int_n !== 1'b0) begin n_fail++; $display("FAIL cap_int_n: got %b, required 0", int_n); end
        n_tests++;
        if (seq !== 8'd1) begin n_fail++; $display("FAIL cap_seq: got %0d, required 1", seq); end
        tick(27);
        spi_cs = 1'b0;
        tick(3);
        n_tests++;
        if (int_n !== 1'b0) begin n_fail++; $display("FAIL cap_int_edge3: got %b, required 0", int_n); end
        tick();
        n_tests++;
        if (int_n !== 1'b1) begin n_fail++; $display("FAIL cap_int_edge4: got %b, required 1", int_n); end
        spi_cs = 1'b1;
        tick(4);
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL cap_read_overrun: got %b, required 0", overrun); end
        // Back in IDLE, a fresh capture must not count as overrun.
        strobe(24'h000321, 24'h000654, 24'h000987, 1'b1);
        n_tests++;
        if (overrun !== 1'b0 || int_n !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_idle_recapture: got overrun=%b int_n=%b, required 0/0", overrun, int_n);
        end
    endtask

    task automatic test_min_hold();
        int lowcnt;
        do_reset();
        strobe(24'h00F00D, 24'h00BEEF, 24'h000042, 1'b1);
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) spi_cs = 1'b0;
            if (int_n === 1'b0) lowcnt++;
            else break;
            tick();
        end
        n_tests++;
        if (lowcnt != 16) begin n_fail++; $display("FAIL min_hold: got %0d cycles low, required 16", lowcnt); end
        spi_cs = 1'b1;
        tick(4);
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL min_hold_overrun: got %b, required 0", overrun); end
    endtask

    task automatic test_strobe_during_read();
        do_reset();
        strobe(24'h000111, 24'h000222, 24'h000333, 1'b1);
        tick(20);
        spi_cs = 1'b0;
        tick(4);
        strobe(24'h00AAAA, 24'h00BBBB, 24'h00CCCC, 1'b0);
        tick(5);
        n_tests++;
        if (count_up !== 24'h000111) begin n_fail++; $display("FAIL read_frozen: got %h, required 000111", count_up); end
        exp_seq = exp_seq + 8'd1;
        exp_q.push_back({24'h00AAAA, 24'h00BBBB, 24'h00CCCC, exp_seq});
        spi_cs = 1'b1;
        tick(2);
        n_tests++;
        if (count_up !== 24'h000111) begin n_fail++; $display("FAIL read_early_commit: got %h, required 000111", count_up); end
        tick();
        n_tests++;
        if (count_up !== 24'h00AAAA || seq !== exp_seq) begin
            n_fail++;
            $display("FAIL read_commit: got up=%h seq=%0d, required 00aaaa seq=%0d", count_up, seq, exp_seq);
        end
        n_tests++;
        if (int_n !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL read_commit_flags: got int_n=%b overrun=%b, required 0/0", int_n, overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        strobe(24'h0000A1, 24'h0000A2, 24'h0000A3, 1'b1);
        strobe(24'h0000B1, 24'h0000B2, 24'h0000B3, 1'b1);
        n_tests++;
        if (seq !== 8'd2 || overrun !== 1'b1 || count_up !== 24'h0000B1) begin
            n_fail++;
            $display("FAIL ovr_double: got seq=%0d overrun=%b up=%h, required 2/1/0000b1", seq, overrun, count_up);
        end
        spi_cs = 1'b0;
        tick(5);
        spi_cs = 1'b1;
        tick(4);
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b, required 0", overrun); end
        spi_cs = 1'b0;
        tick(5);
        strobe(24'h0000C1, 24'h0000C2, 24'h0000C3, 1'b0);
        tick(2);
        strobe(24'h0000D1, 24'h0000D2, 24'h0000D3, 1'b0);
        exp_seq = exp_seq + 8'd1;
        exp_q.push_back({24'h0000D1, 24'h0000D2, 24'h0000D3, exp_seq});
        spi_cs = 1'b1;
        tick(4);
        n_tests++;
        if (overrun !== 1'b1 || count_up !== 24'h0000D1) begin
            n_fail++;
            $display("FAIL ovr_in_read: got overrun=%b up=%h, required 1/0000d1", overrun, count_up);
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        for (int i = 0; i < 256; i++)
            strobe(W'(i), W'(i * 3), W'(i ^ 24'h5A5A5A), 1'b1);
        n_tests++;
        if (seq !== 8'd0) begin n_fail++; $display("FAIL seq_wrap: got %0d, required 0", seq); end
        tick(20);
        spi_cs = 1'b0;
        tick(5);
        strobe(24'h000EEE, 24'h000EEE, 24'h000EEE, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({count_up, count_down, count_rundown, seq} !== '0 || int_n !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got up=%h seq=%0d int_n=%b overrun=%b, required 0/0/1/0",
                     count_up, seq, int_n, overrun);
        end
        exp_q.delete();
        exp_seq = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(10);
        n_tests++;
        if (int_n !== 1'b1 || seq !== 8'd0 || count_up !== '0) begin
            n_fail++;
            $display("FAIL reset_cs_low: got int_n=%b seq=%0d up=%h, required 1/0/0", int_n, seq, count_up);
        end
        spi_cs = 1'b1;
        tick(5);
        n_tests++;
        if (int_n !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cs_release: got int_n=%b overrun=%b, required 1/0", int_n, overrun);
        end
    endtask

`ifdef ADC_INT_TIMEOUT_EN
    task automatic test_timeout();
        int lowcnt;
        do_reset();
        strobe(24'h00ABCD, 24'h001234, 24'h000777, 1'b1);
        lowcnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (int_n === 1'b0) lowcnt++;
            else break;
            tick();
        end
        n_tests++;
        if (lowcnt != 100) begin n_fail++; $display("FAIL timeout_len: got %0d, required 100", lowcnt); end
        n_tests++;
        if (overrun !== 1'b1 || count_up !== 24'h00ABCD) begin
            n_fail++;
            $display("FAIL timeout_state: got overrun=%b up=%h, required 1/00abcd", overrun, count_up);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_capture_read();
        test_min_hold();
        test_strobe_during_read();
        test_overrun();
        test_wrap_reset();
`ifdef ADC_INT_TIMEOUT_EN
        test_timeout();
`endif
        tick(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
